// File: rtl/key_debounce_if.sv
// key_debounce_if: key pins in, debounced level and event pulses out
interface key_debounce_if #(
  parameter int KEY_WIDTH = 4
);
  logic [KEY_WIDTH-1:0] key_n;
  logic [KEY_WIDTH-1:0] key_state;
  logic [KEY_WIDTH-1:0] key_press;
  logic [KEY_WIDTH-1:0] key_release;
  logic [KEY_WIDTH-1:0] key_long;
  modport master (
    output key_n,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long
  );
  modport slave (
    input  key_n,
    output key_state,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronises active-low keys, debounces each one and emits press/release/long pulses
module key_debounce #(
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input logic           clk,
  input logic           rst,
  key_debounce_if.slave b
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, PRESS_FILT, PRESSED, LONG_HELD, REL_FILT} state_t;
  logic [KEY_WIDTH-1:0] sync0, sync1, s, lvl_v, prs_v, rel_v, lng_v;
  always_ff @(posedge clk)
    if (rst) begin
      sync0 <= '1;
      sync1 <= '1;
    end else begin
      sync0 <= b.key_n;
      sync1 <= sync0;
    end
  assign s = ~sync1;
  for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
    state_t        st;
    logic [DW-1:0] dcnt;
    logic [LW-1:0] lcnt;
    logic          long_done, prs, rel, lng;
    always_ff @(posedge clk)
      if (rst) begin
        st        <= IDLE;
        dcnt      <= '0;
        lcnt      <= '0;
        long_done <= 1'b0;
        prs       <= 1'b0;
        rel       <= 1'b0;
        lng       <= 1'b0;
      end else begin
        prs <= 1'b0;
        rel <= 1'b0;
        lng <= 1'b0;
        case (st)
          IDLE:
            if (s[i]) begin
              st   <= PRESS_FILT;
              dcnt <= '0;
            end
          PRESS_FILT:
            if (!s[i]) begin
              st   <= IDLE;
              dcnt <= '0;
            end else if (dcnt == D_LAST) begin
              st   <= PRESSED;
              prs  <= 1'b1;
              lcnt <= '0;
            end else dcnt <= dcnt + 1'b1;
          PRESSED:
            if (!s[i]) begin
              st   <= REL_FILT;
              dcnt <= '0;
            end else if (lcnt == L_LAST) begin
              st        <= LONG_HELD;
              lng       <= 1'b1;
              long_done <= 1'b1;
            end else lcnt <= lcnt + 1'b1;
          LONG_HELD:
            if (!s[i]) begin
              st   <= REL_FILT;
              dcnt <= '0;
            end
          REL_FILT:
            if (s[i]) st <= long_done ? LONG_HELD : PRESSED;
            else if (dcnt == D_LAST) begin
              st        <= IDLE;
              rel       <= 1'b1;
              long_done <= 1'b0;
            end else dcnt <= dcnt + 1'b1;
          default: st <= IDLE;
        endcase
      end
    assign lvl_v[i] = (st == PRESSED) || (st == LONG_HELD) || (st == REL_FILT);
    assign prs_v[i] = prs;
    assign rel_v[i] = rel;
    assign lng_v[i] = lng;
  end
  always_ff @(posedge clk)
    if (rst) begin
      b.key_state   <= '0;
      b.key_press   <= '0;
      b.key_release <= '0;
      b.key_long    <= '0;
    end else begin
      b.key_state   <= lvl_v;
      b.key_press   <= prs_v;
      b.key_release <= rel_v;
      b.key_long    <= lng_v;
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboarded event checks plus inline level checks for key_debounce
module tb_key_debounce;
  localparam int KW = 4, D = 8, L = 32;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, vectors = 0, errors = 0;
  typedef struct {int e; logic [KW-1:0] p, r, l;} exp_t;
  exp_t q[$];
  exp_t x;
  key_debounce_if #(.KEY_WIDTH(KW)) b ();
  key_debounce #(.KEY_WIDTH(KW), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk),
    .rst(rst),
    .b(b)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;
  // any pulse on any output must match the oldest expected event, edge included
  always @(negedge clk)
    if (|{b.key_press, b.key_release, b.key_long}) begin
      vectors++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got p=%b r=%b l=%b want none", cyc, b.key_press, b.key_release, b.key_long);
      end else begin
        x = q.pop_front();
        if (cyc !== x.e || b.key_press !== x.p || b.key_release !== x.r || b.key_long !== x.l) begin
          errors++;
          $display("FAIL event got cyc=%0d p=%b r=%b l=%b want cyc=%0d p=%b r=%b l=%b",
                   cyc, b.key_press, b.key_release, b.key_long, x.e, x.p, x.r, x.l);
        end
      end
    end
  function automatic void push(int e, logic [KW-1:0] p, logic [KW-1:0] r, logic [KW-1:0] l);
    q.push_back('{e, p, r, l});
  endfunction
  task automatic wait_to(int e);
    while (cyc < e) @(negedge clk);
  endtask
  task automatic test_reset();
    int r;
    b.key_n = 4'b1110;
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if ({b.key_state, b.key_press, b.key_release, b.key_long} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got=%h want=0", {b.key_state, b.key_press, b.key_release, b.key_long});
      end
    end
    rst = 1'b0;
    r = cyc + 1;
    push(r + 11, 4'b0001, 4'b0, 4'b0);
    wait_to(r + 10);
    vectors++;
    if (b.key_state !== 4'b0000) begin errors++; $display("FAIL reset_state_early got=%b want=0000", b.key_state); end
    wait_to(r + 11);
    vectors++;
    if (b.key_state !== 4'b0001) begin errors++; $display("FAIL reset_state_accept got=%b want=0001", b.key_state); end
    b.key_n = 4'b1111;
    r = cyc + 1;
    push(r + 11, 4'b0, 4'b0001, 4'b0);
    wait_to(r + 10);
    vectors++;
    if (b.key_state !== 4'b0001) begin errors++; $display("FAIL release_state_early got=%b want=0001", b.key_state); end
    wait_to(r + 11);
    vectors++;
    if (b.key_state !== 4'b0000) begin errors++; $display("FAIL release_state got=%b want=0000", b.key_state); end
  endtask
  task automatic test_long();
    int r;
    b.key_n = 4'b1110;
    r = cyc + 1;
    push(r + 11, 4'b0001, 4'b0, 4'b0);
    push(r + 43, 4'b0, 4'b0, 4'b0001);
    wait_to(r + 60);
    vectors++;
    if (b.key_state !== 4'b0001) begin errors++; $display("FAIL long_state got=%b want=0001", b.key_state); end
    b.key_n = 4'b1111;
    r = cyc + 1;
    push(r + 11, 4'b0, 4'b0001, 4'b0);
    wait_to(r + 12);
    vectors++;
    if (b.key_state !== 4'b0000) begin errors++; $display("FAIL long_release_state got=%b want=0000", b.key_state); end
  endtask
  task automatic test_bounce();
    int r;
    repeat (2) begin
      b.key_n = 4'b1101;
      repeat (5) @(negedge clk);
      b.key_n = 4'b1111;
      repeat (2) @(negedge clk);
    end
    b.key_n = 4'b1101;
    r = cyc + 1;
    push(r + 11, 4'b0010, 4'b0, 4'b0);
    wait_to(r + 10);
    vectors++;
    if (b.key_state !== 4'b0000) begin errors++; $display("FAIL bounce_early got=%b want=0000", b.key_state); end
    wait_to(r + 11);
    vectors++;
    if (b.key_state !== 4'b0010) begin errors++; $display("FAIL bounce_state got=%b want=0010", b.key_state); end
    b.key_n = 4'b1111;
    r = cyc + 1;
    push(r + 11, 4'b0, 4'b0010, 4'b0);
    wait_to(r + 12);
  endtask
  task automatic test_glitch();
    int r;
    b.key_n = 4'b1011;
    r = cyc + 1;
    push(r + 11, 4'b0100, 4'b0, 4'b0);
    wait_to(r + 12);
    vectors++;
    if (b.key_state !== 4'b0100) begin errors++; $display("FAIL glitch_pressed got=%b want=0100", b.key_state); end
    b.key_n = 4'b1111;
    repeat (4) @(negedge clk);
    b.key_n = 4'b1011;
    repeat (6) @(negedge clk);
    vectors++;
    if (b.key_state !== 4'b0100) begin errors++; $display("FAIL glitch_state got=%b want=0100", b.key_state); end
    b.key_n = 4'b1111;
    r = cyc + 1;
    push(r + 11, 4'b0, 4'b0100, 4'b0);
    wait_to(r + 10);
    vectors++;
    if (b.key_state !== 4'b0100) begin errors++; $display("FAIL glitch_rel_early got=%b want=0100", b.key_state); end
    wait_to(r + 11);
    vectors++;
    if (b.key_state !== 4'b0000) begin errors++; $display("FAIL glitch_released got=%b want=0000", b.key_state); end
  endtask
  task automatic test_back_to_back();
    int r;
    b.key_n = 4'b0110;
    r = cyc + 1;
    push(r + 11, 4'b1001, 4'b0, 4'b0);
    wait_to(r + 12);
    vectors++;
    if (b.key_state !== 4'b1001) begin errors++; $display("FAIL simul_state got=%b want=1001", b.key_state); end
    b.key_n = 4'b1111;
    r = cyc + 1;
    push(r + 11, 4'b0, 4'b1001, 4'b0);
    wait_to(r + 12);
    vectors++;
    if (b.key_state !== 4'b0000) begin errors++; $display("FAIL simul_release got=%b want=0000", b.key_state); end
  endtask
  task automatic test_reset_mid();
    int r;
    b.key_n = 4'b1011;
    r = cyc + 1;
    push(r + 11, 4'b0100, 4'b0, 4'b0);
    push(r + 43, 4'b0, 4'b0, 4'b0100);
    wait_to(r + 46);
    b.key_n = 4'b1001;
    r = cyc + 1;
    wait_to(r + 7);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({b.key_state, b.key_press, b.key_release, b.key_long} !== '0) begin
        errors++;
        $display("FAIL midreset_outputs got=%h want=0", {b.key_state, b.key_press, b.key_release, b.key_long});
      end
    end
    rst = 1'b0;
    r = cyc + 1;
    push(r + 11, 4'b0110, 4'b0, 4'b0);
    wait_to(r + 10);
    vectors++;
    if (b.key_state !== 4'b0000) begin errors++; $display("FAIL midreset_early got=%b want=0000", b.key_state); end
    wait_to(r + 11);
    vectors++;
    if (b.key_state !== 4'b0110) begin errors++; $display("FAIL midreset_repress got=%b want=0110", b.key_state); end
    b.key_n = 4'b1111;
    r = cyc + 1;
    push(r + 11, 4'b0, 4'b0110, 4'b0);
    wait_to(r + 12);
    vectors++;
    if (b.key_state !== 4'b0000) begin errors++; $display("FAIL midreset_release got=%b want=0000", b.key_state); end
  endtask
  initial begin
    test_reset();
    test_long();
    test_bounce();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
